ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register and memory-access sequencer. Sits directly downstream of the ALU.
- Latches the ALU result, store data and control bits each cycle.
- For loads/stores, drives a request/ack handshake to the dcache and stalls the upstream pipeline until the access completes.
- Feeds the MEM/WB outputs, which hold write-back data, to the register-file write port.

Parameters:
- DATA_W, 32, datapath width: ALU result, store data, load data.
- RA_W, 5, destination register address width.
- MAX_WAIT, 255, maximum cycles to wait for mem_ack_i before declaring a timeout; range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX stage holds a real instruction.
- ALU_result_i  in  DATA_W  ALU data_o; the address for loads/stores.
- RTdata_i  in  DATA_W  store data.
- RDaddr_i  in  RA_W  destination register.
- RegWrite_i  in  1  instruction writes the register file.
- MemtoReg_i  in  1  write-back selects load data.
- MemRead_i  in  1  load.
- MemWrite_i  in  1  store.
- flush_i  in  1  kill the instruction entering this stage.
- stall_o  out  1  hold IF/ID/EX and do not change EX inputs.
- mem_req_o  out  1  dcache request (level).
- mem_write_o  out  1  1 = store, 0 = load.
- mem_addr_o  out  DATA_W  word address, bits[1:0] = 0.
- mem_wdata_o  out  DATA_W  store data.
- mem_ack_i  in  1  one-cycle completion pulse; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  DATA_W  load data.
- wb_valid_o  out  1  MEM/WB holds a completed instruction.
- wb_RegWrite_o  out  1  write enable to the register file.
- wb_RDaddr_o  out  RA_W  write address.
- wb_data_o  out  DATA_W  write-back value: load data if MemtoReg, else ALU result.
- exc_o  out  1  one-cycle pulse on a misaligned access or timeout.

Behaviour:
- Reset (rst_i = 0, asynchronous): all EX/MEM and MEM/WB registers, outputs, FSM state and wait counter go to 0; state = IDLE.
- FSM states: IDLE and ACCESS.
- stall_o = (state == ACCESS) & ~mem_ack_i. This is combinational; there is no stall in the ack cycle.
- EX/MEM capture occurs on every edge where stall_o = 0.
  - If flush_i = 1 or ex_valid_i = 0: a bubble is captured (all control bits 0).
  - Otherwise all EX inputs are captured.
- While stalled, EX/MEM holds its contents. flush_i is ignored because the upstream stage is held.
- IDLE to ACCESS: when a valid captured instruction has (MemRead | MemWrite) and address bits[1:0] = 0.
  - mem_req_o, mem_write_o, mem_addr_o and mem_wdata_o are registered.
  - They assert on the capture edge and stay constant until the ack cycle.
- ACCESS to IDLE: on mem_ack_i.
  - mem_req_o drops on the following edge.
  - MEM/WB captures on the same edge. Load data comes from mem_rdata_i.
  - EX/MEM captures the next instruction on that same edge. Back-to-back memory ops re-enter ACCESS with no idle cycle.
- mem_ack_i while in IDLE is ignored.
- Non-memory instruction latency: EX input to wb_* is 2 edges. Memory op latency: 2 + N, where N is the number of cycles before the ack.
- MEM/WB captures every non-stalled edge.
  - wb_valid_o = captured valid.
  - wb_RegWrite_o = valid & RegWrite.
  - Stores produce wb_valid_o = 1 with wb_RegWrite_o = 0.
- Misaligned memory op (bits[1:0] != 0):
  - No request and no stall.
  - Completes as a bubble: wb_valid_o = 1, wb_RegWrite_o = 0.
  - exc_o pulses in the same cycle the op reaches MEM/WB.
- Timeout: an 8-bit wait counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When it reaches MAX_WAIT: return to IDLE, drop mem_req_o, retire as in the misaligned case, and pulse exc_o.
  - The counter saturates and does not wrap.
- Reset mid-ACCESS: mem_req_o drops immediately and the instruction is lost. No recovery is required.
- Simultaneous ack and timeout in the same cycle: the ack wins and the data is written back.

Test Plan:
- add result 0x0000_0010 with RegWrite = 1, RD = 3 -> 2 edges later: wb_valid_o = 1, wb_RDaddr_o = 3, wb_data_o = 0x10; stall_o stays 0.
- load at addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF -> mem_req_o high for 4 cycles, mem_addr_o = 0x40, stall_o high for 3 cycles, then wb_data_o = 0xDEADBEEF.
- store at 0x44 with data 0x1234 followed by a load at 0x48, each acked in 1 cycle -> second request asserted the edge after the first ack, with no gap; store retires with wb_RegWrite_o = 0.
- load at address 0x42 -> mem_req_o never asserts, exc_o pulses once, wb_RegWrite_o = 0.
- MAX_WAIT = 4 with mem_ack_i held at 0 -> stall_o high for 4 cycles, then mem_req_o = 0 and exc_o pulses; a following add completes normally.
- flush_i = 1 with a valid load in EX -> no request issued, wb_valid_o = 0; reset asserted mid-ACCESS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register plus memory-access sequencer, followed by the
//   MEM/WB register that feeds the register-file write port.
//
//   Upstream (EX) side:
//     ex_valid_i, ALU_result_i, RTdata_i, RDaddr_i, RegWrite_i, MemtoReg_i,
//     MemRead_i, MemWrite_i, flush_i   -> instruction entering this stage
//     stall_o                          -> hold IF/ID/EX, keep EX inputs stable
//   dcache side:
//     mem_req_o/mem_write_o/mem_addr_o/mem_wdata_o (registered, level)
//     mem_ack_i (one-cycle pulse), mem_rdata_i (valid with ack)
//   Write-back side:
//     wb_valid_o, wb_RegWrite_o, wb_RDaddr_o, wb_data_o, exc_o
//   Debug:
//     state_dbg_o                      -> FSM state (0 = IDLE, 1 = ACCESS)
//
//   Handshake: mem_req_o is raised on the edge that captures an aligned
//   load/store and stays constant (with address/data/direction) until the
//   cycle in which mem_ack_i is high. That ack cycle completes the access:
//   on the following edge MEM/WB captures the result and EX/MEM captures
//   the next instruction, so back-to-back accesses keep mem_req_o high.
//   stall_o is combinational and is low in the ack cycle.
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [RA_W-1:0]   RDaddr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_RegWrite_o,
  output logic [RA_W-1:0]   wb_RDaddr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              exc_o,
  output logic              state_dbg_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Timeout fires in the MAX_WAIT-th consecutive ACCESS cycle without ack.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;

  // EX/MEM register
  logic              em_valid;
  logic              em_regwrite;
  logic              em_memtoreg;
  logic              em_memread;
  logic              em_memwrite;
  logic [DATA_W-1:0] em_alu;
  logic [DATA_W-1:0] em_rtdata;
  logic [RA_W-1:0]   em_rd;

  logic ack_hit;
  logic timeout;
  logic em_misaligned;
  logic ex_take;
  logic ex_mem_go;

  assign state_dbg_o   = (state == ACCESS);
  assign stall_o       = (state == ACCESS) & ~mem_ack_i;
  assign ack_hit       = (state == ACCESS) & mem_ack_i;
  // Ack has priority over timeout in the same cycle.
  assign timeout       = (state == ACCESS) & ~mem_ack_i & (wait_cnt == WAIT_LAST);
  assign em_misaligned = em_valid & (em_memread | em_memwrite) & (em_alu[1:0] != 2'b00);
  assign ex_take       = ex_valid_i & ~flush_i;
  assign ex_mem_go     = ex_take & (MemRead_i | MemWrite_i) & (ALU_result_i[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      em_valid      <= 1'b0;
      em_regwrite   <= 1'b0;
      em_memtoreg   <= 1'b0;
      em_memread    <= 1'b0;
      em_memwrite   <= 1'b0;
      em_alu        <= '0;
      em_rtdata     <= '0;
      em_rd         <= '0;
      mem_req_o     <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      wb_valid_o    <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      wb_RDaddr_o   <= '0;
      wb_data_o     <= '0;
      exc_o         <= 1'b0;
    end else if (!stall_o) begin
      // EX/MEM capture; a flushed or invalid slot becomes a bubble.
      em_valid    <= ex_take;
      em_regwrite <= ex_take & RegWrite_i;
      em_memtoreg <= ex_take & MemtoReg_i;
      em_memread  <= ex_take & MemRead_i;
      em_memwrite <= ex_take & MemWrite_i;
      em_alu      <= ALU_result_i;
      em_rtdata   <= RTdata_i;
      em_rd       <= RDaddr_i;

      // MEM/WB capture. Stores and misaligned ops retire without a write.
      wb_valid_o    <= em_valid;
      wb_RegWrite_o <= em_valid & em_regwrite & ~em_memwrite & ~em_misaligned;
      wb_RDaddr_o   <= em_rd;
      wb_data_o     <= (ack_hit & em_memtoreg) ? mem_rdata_i : em_alu;
      exc_o         <= em_misaligned;

      // Sequencer: start a new access straight from the EX inputs so the
      // request appears on the same edge the op is captured.
      if (ex_mem_go) begin
        state       <= ACCESS;
        mem_req_o   <= 1'b1;
        mem_write_o <= MemWrite_i;
        mem_addr_o  <= {ALU_result_i[DATA_W-1:2], 2'b00};
        mem_wdata_o <= RTdata_i;
        wait_cnt    <= 8'd0;
      end else begin
        state       <= IDLE;
        mem_req_o   <= 1'b0;
        mem_write_o <= 1'b0;
      end
    end else if (timeout) begin
      // Abandon the access; the op retires as a non-writing bubble and the
      // EX/MEM slot is emptied so it is not retired a second time.
      state         <= IDLE;
      mem_req_o     <= 1'b0;
      mem_write_o   <= 1'b0;
      em_valid      <= 1'b0;
      em_regwrite   <= 1'b0;
      em_memtoreg   <= 1'b0;
      em_memread    <= 1'b0;
      em_memwrite   <= 1'b0;
      wb_valid_o    <= em_valid;
      wb_RegWrite_o <= 1'b0;
      wb_RDaddr_o   <= em_rd;
      wb_data_o     <= em_alu;
      exc_o         <= 1'b1;
    end else begin
      // Waiting for ack: MEM/WB presents no new completion while stalled,
      // so each instruction retires with exactly one wb_valid_o pulse.
      wb_valid_o    <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      exc_o         <= 1'b0;
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;

  logic              clk;
  logic              rst_n;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rt_data;
  logic [RA_W-1:0]   rd_addr;
  logic              reg_write;
  logic              mem_to_reg;
  logic              mem_read;
  logic              mem_write;
  logic              flush;
  logic              stall;
  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              exc;
  logic              state_dbg;

  int n_run;
  int n_fail;

  ex_mem_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .MAX_WAIT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .ex_valid_i   (ex_valid),
    .ALU_result_i (alu_result),
    .RTdata_i     (rt_data),
    .RDaddr_i     (rd_addr),
    .RegWrite_i   (reg_write),
    .MemtoReg_i   (mem_to_reg),
    .MemRead_i    (mem_read),
    .MemWrite_i   (mem_write),
    .flush_i      (flush),
    .stall_o      (stall),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .wb_valid_o   (wb_valid),
    .wb_RegWrite_o(wb_reg_write),
    .wb_RDaddr_o  (wb_rd),
    .wb_data_o    (wb_data),
    .exc_o        (exc),
    .state_dbg_o  (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rt,
                        input logic [RA_W-1:0] rd, input logic rw, input logic m2r,
                        input logic mr, input logic mw);
    ex_valid   = 1'b1;
    alu_result = alu;
    rt_data    = rt;
    rd_addr    = rd;
    reg_write  = rw;
    mem_to_reg = m2r;
    mem_read   = mr;
    mem_write  = mw;
  endtask

  task automatic set_nop;
    ex_valid   = 1'b0;
    alu_result = '0;
    rt_data    = '0;
    rd_addr    = '0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_nop();
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", mem_req); end
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_run++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb got v=%0b rw=%0b want 0/0", wb_valid, wb_reg_write); end
    n_run++; if (wb_data !== 32'h0 || mem_addr !== 32'h0 || exc !== 1'b0) begin n_fail++; $display("FAIL reset_data got wb=%h addr=%h exc=%0b want 0", wb_data, mem_addr, exc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ALU op: 2-edge latency; an ack seen while IDLE must be ignored.
  task automatic test_alu;
    tick();
    set_ex(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    set_nop();
    #1;
    n_run++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_no_stall got stall=%0b req=%0b want 0/0", stall, mem_req); end
    n_run++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_early_wb got %0b want 0", wb_valid); end
    tick();
    mem_ack = 1'b0;
    #1;
    n_run++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid got v=%0b rw=%0b want 1/1", wb_valid, wb_reg_write); end
    n_run++; if (wb_rd !== 5'd3 || wb_data !== 32'h10) begin n_fail++; $display("FAIL alu_wb_data got rd=%0d data=%h want 3/00000010", wb_rd, wb_data); end
    n_run++; if (stall !== 1'b0 || exc !== 1'b0) begin n_fail++; $display("FAIL alu_stall_exc got stall=%0b exc=%0b want 0/0", stall, exc); end
    tick();
    #1;
    n_run++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0b want 0", wb_valid); end
  endtask

  // Load at 0x40 acked in the 4th ACCESS cycle.
  task automatic test_load;
    tick();
    set_ex(32'h40, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_nop();
    #1;
    n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL load_req got req=%0b addr=%h wr=%0b want 1/00000040/0", mem_req, mem_addr, mem_wr); end
    n_run++; if (stall !== 1'b1 || state_dbg !== 1'b1) begin n_fail++; $display("FAIL load_stall_c1 got stall=%0b st=%0b want 1/1", stall, state_dbg); end
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_run++; if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL load_wait_c%0d got req=%0b stall=%0b addr=%h want 1/1/00000040", i, mem_req, stall, mem_addr); end
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_run++; if (mem_req !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL load_ack_cycle got req=%0b stall=%0b want 1/0", mem_req, stall); end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop got %0b want 0", mem_req); end
    n_run++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL load_wb_ctrl got v=%0b rw=%0b rd=%0d want 1/1/5", wb_valid, wb_reg_write, wb_rd); end
    n_run++; if (wb_data !== 32'hDEADBEEF || exc !== 1'b0) begin n_fail++; $display("FAIL load_wb_data got %h exc=%0b want deadbeef/0", wb_data, exc); end
  endtask

  // Store 0x44 then load 0x48, each acked in its first ACCESS cycle.
  task automatic test_back_to_back;
    tick();
    set_ex(32'h44, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ex(32'h48, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    mem_ack = 1'b1;
    #1;
    n_run++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL b2b_store_req got req=%0b wr=%0b addr=%h wd=%h want 1/1/00000044/00001234", mem_req, mem_wr, mem_addr, mem_wdata); end
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_store_ack_stall got %0b want 0", stall); end
    tick();
    set_nop();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    n_run++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h48) begin n_fail++; $display("FAIL b2b_load_req got req=%0b wr=%0b addr=%h want 1/0/00000048", mem_req, mem_wr, mem_addr); end
    n_run++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_store_retire got v=%0b rw=%0b want 1/0", wb_valid, wb_reg_write); end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    n_run++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_load_retire got req=%0b v=%0b rw=%0b want 0/1/1", mem_req, wb_valid, wb_reg_write); end
    n_run++; if (wb_data !== 32'hCAFEF00D || wb_rd !== 5'd6) begin n_fail++; $display("FAIL b2b_load_data got %h rd=%0d want cafef00d/6", wb_data, wb_rd); end
  endtask

  task automatic test_misaligned;
    tick();
    set_ex(32'h42, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_nop();
    #1;
    n_run++; if (mem_req !== 1'b0 || stall !== 1'b0 || exc !== 1'b0) begin n_fail++; $display("FAIL mis_no_req got req=%0b stall=%0b exc=%0b want 0/0/0", mem_req, stall, exc); end
    tick();
    n_run++; if (exc !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_retire got exc=%0b v=%0b rw=%0b req=%0b want 1/1/0/0", exc, wb_valid, wb_reg_write, mem_req); end
    tick();
    n_run++; if (exc !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got exc=%0b v=%0b want 0/0", exc, wb_valid); end
  endtask

  // MAX_WAIT = 4, no ack: four stall cycles, then timeout and a clean add.
  task automatic test_timeout;
    tick();
    set_ex(32'h80, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_nop();
    #1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      n_run++; if (stall !== 1'b1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL to_wait_c%0d got stall=%0b req=%0b want 1/1", i, stall, mem_req); end
    end
    tick();
    set_ex(32'h99, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (mem_req !== 1'b0 || stall !== 1'b0 || exc !== 1'b1) begin n_fail++; $display("FAIL to_expire got req=%0b stall=%0b exc=%0b want 0/0/1", mem_req, stall, exc); end
    n_run++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL to_retire got v=%0b rw=%0b want 1/0", wb_valid, wb_reg_write); end
    tick();
    set_nop();
    #1;
    n_run++; if (exc !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL to_after got exc=%0b v=%0b want 0/0", exc, wb_valid); end
    tick();
    n_run++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_data !== 32'h99 || wb_rd !== 5'd4) begin n_fail++; $display("FAIL to_next_add got v=%0b rw=%0b data=%h rd=%0d want 1/1/00000099/4", wb_valid, wb_reg_write, wb_data, wb_rd); end
  endtask

  // Ack arriving in the same cycle the timeout would fire: ack wins.
  task automatic test_ack_at_limit;
    tick();
    set_ex(32'h84, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_nop();
    tick();
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    #1;
    n_run++; if (stall !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL lim_ack_cycle got stall=%0b req=%0b want 0/1", stall, mem_req); end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    n_run++; if (exc !== 1'b0 || wb_reg_write !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd10) begin n_fail++; $display("FAIL lim_ack_wins got exc=%0b rw=%0b data=%h rd=%0d want 0/1/00000055/10", exc, wb_reg_write, wb_data, wb_rd); end
  endtask

  task automatic test_flush;
    tick();
    set_ex(32'h40, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_nop();
    #1;
    n_run++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_no_req got req=%0b stall=%0b want 0/0", mem_req, stall); end
    tick();
    n_run++; if (wb_valid !== 1'b0 || exc !== 1'b0) begin n_fail++; $display("FAIL flush_wb got v=%0b exc=%0b want 0/0", wb_valid, exc); end
  endtask

  task automatic test_reset_mid_access;
    tick();
    set_ex(32'h40, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_nop();
    #1;
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got req=%0b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_run++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || state_dbg !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got req=%0b stall=%0b addr=%h st=%0b want 0/0/0/0", mem_req, stall, mem_addr, state_dbg); end
    n_run++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || exc !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb got v=%0b data=%h exc=%0b want 0/0/0", wb_valid, wb_data, exc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_run++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lost got req=%0b v=%0b want 0/0", mem_req, wb_valid); end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_ack_at_limit();
    test_flush();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", n_run);
    $fatal(1, "watchdog");
  end

endmodule
